// File: rtl/text_char_renderer.sv
// Text-mode pixel pipeline: raster position -> text RAM read -> font ROM address -> serialised
// RGB444 pixel, with syncs delayed to match and a blinking cursor overlaid on the character grid.
module text_char_renderer #(
    parameter int          TEXT_COLS        = 80,
    parameter int          TEXT_ROWS        = 30,
    parameter logic [11:0] FG_COLOR         = 12'hFFF,
    parameter logic [11:0] BG_COLOR         = 12'h000,
    parameter int          BLINK_FRAMES     = 30,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_data,
    output logic [10:0] font_bitmap_addr,
    input  logic [7:0]  font_bitmap_byte,
    output logic [11:0] rgb,
    output logic        text_pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out
);

    localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]      COLS_L  = 8'(TEXT_COLS);
    localparam logic [6:0]      ROWS_L  = 7'(TEXT_ROWS);

    function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        return 12'(12'(row) * 12'(TEXT_COLS)) + 12'(col);
    endfunction

    logic [6:0] col_p1;
    logic [5:0] cell_row_p1;
    logic [3:0] glyph_row_p1, glyph_row_p2;
    logic [2:0] bit_sel_p1, bit_sel_p2, bit_sel_p3;
    logic       cur_hit_p1, cur_hit_p2, cur_hit_p3;
    logic       in_region_p1, in_region_p2, in_region_p3;
    logic       hsync_p1, hsync_p2, hsync_p3;
    logic       vsync_p1, vsync_p2, vsync_p3;
    logic       vld_p1, vld_p2, vld_p3;
    logic       inv_p3;
    logic       cur_match, lit;
    logic            vsync_q, vs_edge, blink_phase;
    logic [FC_W-1:0] frame_cnt;

    // An off-grid cursor position can never match a visible cell.
    assign cur_match = cursor_en
                       && (pixel_x[9:3] == cursor_col)
                       && (pixel_y[9:4] == {1'b0, cursor_row})
                       && ({1'b0, cursor_col} < COLS_L)
                       && ({2'b0, cursor_row} < ROWS_L);

    // ---- S1: split raster position into cell / glyph coordinates ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p1       <= '0;
            cell_row_p1  <= '0;
            glyph_row_p1 <= '0;
            bit_sel_p1   <= '0;
            cur_hit_p1   <= 1'b0;
            hsync_p1     <= 1'b0;
            vsync_p1     <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            col_p1       <= pixel_x[9:3];
            cell_row_p1  <= pixel_y[9:4];
            glyph_row_p1 <= pixel_y[3:0];
            bit_sel_p1   <= pixel_x[2:0];
            cur_hit_p1   <= cur_match;
            hsync_p1     <= hsync_in;
            vsync_p1     <= vsync_in;
            vld_p1       <= video_on;
        end
    end

    assign in_region_p1 = ({1'b0, col_p1} < COLS_L) && ({1'b0, cell_row_p1} < ROWS_L);
    assign text_addr    = in_region_p1 ? cell_addr(cell_row_p1, col_p1) : 12'd0;

    // ---- S2: text RAM data returns, form the font ROM address ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glyph_row_p2 <= '0;
            bit_sel_p2   <= '0;
            in_region_p2 <= 1'b0;
            cur_hit_p2   <= 1'b0;
            hsync_p2     <= 1'b0;
            vsync_p2     <= 1'b0;
            vld_p2       <= 1'b0;
        end else begin
            glyph_row_p2 <= glyph_row_p1;
            bit_sel_p2   <= bit_sel_p1;
            in_region_p2 <= in_region_p1;
            cur_hit_p2   <= cur_hit_p1;
            hsync_p2     <= hsync_p1;
            vsync_p2     <= vsync_p1;
            vld_p2       <= vld_p1;
        end
    end

    assign font_bitmap_addr = {text_data[6:0], glyph_row_p2};

    // ---- S3: font byte returns, pick the pixel bit ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_sel_p3   <= '0;
            inv_p3       <= 1'b0;
            in_region_p3 <= 1'b0;
            cur_hit_p3   <= 1'b0;
            hsync_p3     <= 1'b0;
            vsync_p3     <= 1'b0;
            vld_p3       <= 1'b0;
        end else begin
            bit_sel_p3   <= bit_sel_p2;
            inv_p3       <= text_data[7];
            in_region_p3 <= in_region_p2;
            cur_hit_p3   <= cur_hit_p2;
            hsync_p3     <= hsync_p2;
            vsync_p3     <= vsync_p2;
            vld_p3       <= vld_p2;
        end
    end

    // Inverse and an active cursor each flip the pixel, so together they cancel.
    assign lit = font_bitmap_byte[3'd7 - bit_sel_p3] ^ inv_p3 ^ (cur_hit_p3 & blink_phase);

    // ---- Output: registered colour, lit flag and delayed syncs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb          <= '0;
            text_pixel   <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            video_on_out <= 1'b0;
        end else begin
            if (vld_p3 && in_region_p3) rgb <= lit ? FG_COLOR : BG_COLOR;
            else                        rgb <= 12'h000;
            text_pixel   <= lit & in_region_p3 & vld_p3;
            hsync_out    <= hsync_p3;
            vsync_out    <= vsync_p3;
            video_on_out <= vld_p3;
        end
    end

    assign vs_edge = VSYNC_ACTIVE_LOW ? (vsync_q & ~vsync_in) : (~vsync_q & vsync_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            if (vs_edge) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_char_renderer.sv
// Bench for text_char_renderer: text RAM / font ROM models, directed glyph, addressing and cursor
// cases, then randomized raster traffic against a cell-level reference model.
module tb_text_char_renderer;

    localparam int          BF = 2;
    localparam logic [11:0] FG = 12'hEA5;
    localparam logic [11:0] BG = 12'h124;

    logic        clk, rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync_in, vsync_in;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_en;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [10:0] font_bitmap_addr;
    logic [7:0]  font_bitmap_byte;
    logic [11:0] rgb;
    logic        text_pixel, hsync_out, vsync_out, video_on_out;

    text_char_renderer #(
        .TEXT_COLS(80), .TEXT_ROWS(30), .FG_COLOR(FG), .BG_COLOR(BG),
        .BLINK_FRAMES(BF), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .text_addr(text_addr), .text_data(text_data),
        .font_bitmap_addr(font_bitmap_addr), .font_bitmap_byte(font_bitmap_byte),
        .rgb(rgb), .text_pixel(text_pixel), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .video_on_out(video_on_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    logic [7:0] rom [0:2047];

    always @(posedge clk) begin
        text_data        <= ram[text_addr];
        font_bitmap_byte <= rom[font_bitmap_addr];
    end

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic [6:0] ccol;
        logic [4:0] crow;
        logic       cen;
    } smp_t;

    smp_t hist[$];
    int   cum[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_addr(input smp_t s);
        int col, row;
        col = int'(s.x) / 8;
        row = int'(s.y) / 16;
        if (col < 80 && row < 30) return row * 80 + col;
        return 0;
    endfunction

    function automatic smp_t mk(input int x, input int y, input bit von, input bit vs, input bit cen);
        smp_t s;
        s.x = 10'(x); s.y = 10'(y); s.von = von; s.hs = 1'b1; s.vs = vs;
        s.ccol = 7'd0; s.crow = 5'd0; s.cen = cen;
        return s;
    endfunction

    // Apply one pixel, clock it, then check every output against the model.
    task automatic step(input smp_t s);
        int n, m, col, row, xi;
        bit inreg, hit, phase, lit, prev;
        logic [7:0] ch, fb;
        smp_t p;
        pixel_x = s.x; pixel_y = s.y; video_on = s.von; hsync_in = s.hs; vsync_in = s.vs;
        cursor_col = s.ccol; cursor_row = s.crow; cursor_en = s.cen;
        @(posedge clk);
        #1;
        n = hist.size();
        hist.push_back(s);
        prev = (n == 0) ? 1'b0 : hist[n-1].vs;
        cum.push_back(((n == 0) ? 0 : cum[n-1]) + ((prev && !s.vs) ? 1 : 0));
        check_eq("text_addr", text_addr, ref_addr(s));
        if (n >= 1) begin
            p  = hist[n-1];
            ch = ram[ref_addr(p)];
            check_eq("font_addr", font_bitmap_addr, {ch[6:0], p.y[3:0]});
        end
        if (n >= 3) begin
            m     = n - 3;
            p     = hist[m];
            xi    = int'(p.x);
            col   = xi / 8;
            row   = int'(p.y) / 16;
            inreg = (col < 80) && (row < 30);
            ch    = ram[ref_addr(p)];
            fb    = rom[{ch[6:0], p.y[3:0]}];
            hit   = p.cen && (col == int'(p.ccol)) && (row == int'(p.crow));
            phase = ((cum[m+2] / BF) % 2) == 1;
            lit   = fb[7 - (xi % 8)] ^ ch[7] ^ (hit && phase);
            check_eq("text_pixel", text_pixel, lit && inreg && p.von);
            check_eq("rgb", rgb, (p.von && inreg) ? (lit ? FG : BG) : 12'h000);
            check_eq("hsync_out", hsync_out, p.hs);
            check_eq("vsync_out", vsync_out, p.vs);
            check_eq("video_on_out", video_on_out, p.von);
        end else begin
            check_eq("pre_text_pixel", text_pixel, 0);
            check_eq("pre_rgb", rgb, 0);
            check_eq("pre_syncs", {hsync_out, vsync_out, video_on_out}, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rgb"}, rgb, 0);
        check_eq({tag, "_text_addr"}, text_addr, 0);
        check_eq({tag, "_syncs"}, {hsync_out, vsync_out, video_on_out, text_pixel}, 0);
    endtask

    task automatic reset_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            pixel_x = 10'($urandom); pixel_y = 10'($urandom);
            video_on = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        rst_n = 1'b1;
        hist.delete();
        cum.delete();
    endtask

    // One 8-pixel glyph row of cell (0,0), followed by pads at cell (1,1).
    task automatic row_pass(input int y, input bit cen, input logic [7:0] exp_bits,
                            input logic [10:0] exp_faddr, input string tag);
        logic [7:0] bits;
        bits = 8'h00;
        for (int i = 0; i < 11; i++) begin
            step(mk((i < 8) ? i : 8, (i < 8) ? y : 16, 1'b1, 1'b1, cen));
            if (i == 1) check_eq({tag, "_faddr"}, font_bitmap_addr, exp_faddr);
            if (i >= 3) bits = {bits[6:0], text_pixel};
        end
        check_eq({tag, "_bits"}, bits, exp_bits);
    endtask

    task automatic pads(input int k, input bit cen);
        for (int i = 0; i < k; i++) step(mk(8, 16, 1'b1, 1'b1, cen));
    endtask

    task automatic vs_pulses(input int k, input bit cen);
        for (int i = 0; i < k; i++) begin
            step(mk(8, 16, 1'b1, 1'b0, cen));
            step(mk(8, 16, 1'b1, 1'b1, cen));
        end
    endtask

    task automatic random_traffic(input int cycles);
        smp_t s;
        bit von, hs, vs, cen;
        int ccol, crow, x, y;
        von = 1'b1; hs = 1'b1; vs = 1'b1; cen = 1'b0; ccol = 0; crow = 0;
        for (int c = 0; c < cycles; c++) begin
            if (c % 200 == 0) begin
                cen  = ($urandom_range(0, 3) != 0);
                ccol = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 79));
                crow = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 29));
            end
            if ($urandom_range(0, 7) == 0)  von = ~von;
            if ($urandom_range(0, 7) == 0)  hs  = ~hs;
            if ($urandom_range(0, 29) == 0) vs  = ~vs;
            if ($urandom_range(0, 2) == 0) begin
                x = ccol * 8 + int'($urandom_range(0, 7));
                y = crow * 16 + int'($urandom_range(0, 15));
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end
            s = mk(x, y, von, vs, cen);
            s.hs = hs; s.ccol = 7'(ccol); s.crow = 5'(crow);
            step(s);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        ram[0]     = 8'h41;
        ram[81]    = 8'h20;
        rom[11'h417] = 8'hFE;
        rom[11'h412] = 8'h10;
        rst_n = 1'b0;
        cursor_col = '0; cursor_row = '0; cursor_en = 1'b0;
        reset_cycles(5);

        row_pass(7, 1'b0, 8'hFE, 11'h417, "glyph_row7");
        row_pass(2, 1'b0, 8'h10, 11'h412, "glyph_row2");

        step(mk(639, 479, 1'b1, 1'b1, 1'b0));
        check_eq("addr_2399", text_addr, 12'd2399);
        step(mk(24, 160, 1'b1, 1'b1, 1'b0));
        check_eq("addr_803", text_addr, 12'd803);
        pads(4, 1'b0);

        ram[0] = 8'hC1;
        row_pass(7, 1'b0, 8'h01, 11'h417, "inverse");
        row_pass(7, 1'b1, 8'h01, 11'h417, "cursor_off_phase");
        vs_pulses(2, 1'b1);
        row_pass(7, 1'b1, 8'hFE, 11'h417, "cursor_on_phase");
        vs_pulses(2, 1'b1);
        row_pass(7, 1'b1, 8'h01, 11'h417, "cursor_back");

        random_traffic(3000);

        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        reset_cycles(3);
        random_traffic(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
